// File: rtl/pmem_line_responder.sv
// Cache-line responder: turns one 256-bit line read/write from the cache into a
// BEATS-long burst on the 64-bit memory bus and returns a single-cycle completion pulse.
module pmem_line_responder #(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned BEAT_W = 64,
    parameter int unsigned BEATS  = LINE_W / BEAT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pmem_address,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [LINE_W-1:0] pmem_wdata,
    output logic [LINE_W-1:0] pmem_rdata,
    output logic              pmem_resp,
    output logic [31:0]       mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [BEAT_W-1:0] mem_wdata,
    input  logic [BEAT_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    localparam int unsigned CntW = (BEATS > 1) ? $clog2(BEATS) : 1;
    // Byte offset within a line; these address bits are dropped on acceptance.
    localparam logic [31:0] OffMask = 32'(LINE_W / 8 - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [LINE_W-1:0] pmem_rdata_q, pmem_rdata_d;
    logic              pmem_resp_q, pmem_resp_d;
    logic [31:0]       mem_address_q, mem_address_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [BEAT_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              last_beat;

    assign last_beat = (cnt_q == CntW'(BEATS - 1));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        line_d        = line_q;
        pmem_rdata_d  = pmem_rdata_q;
        pmem_resp_d   = 1'b0;
        mem_address_d = mem_address_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_wdata_d   = mem_wdata_q;

        case (state_q)
            StIdle: begin
                // Write has priority; a read held alongside it is taken after completion.
                if (pmem_write) begin
                    state_d       = StWrite;
                    cnt_d         = '0;
                    mem_address_d = pmem_address & ~OffMask;
                    line_d        = pmem_wdata;
                    mem_write_d   = 1'b1;
                    mem_wdata_d   = pmem_wdata[BEAT_W-1:0];
                end else if (pmem_read) begin
                    state_d       = StRead;
                    cnt_d         = '0;
                    mem_address_d = pmem_address & ~OffMask;
                    mem_read_d    = 1'b1;
                end
            end

            StRead: begin
                if (mem_resp) begin
                    line_d[cnt_q*BEAT_W +: BEAT_W] = mem_rdata;
                    cnt_d                          = cnt_q + CntW'(1);
                    if (last_beat) begin
                        state_d      = StDone;
                        mem_read_d   = 1'b0;
                        pmem_resp_d  = 1'b1;
                        // Publish the whole line at once so partial bursts never leak out.
                        pmem_rdata_d = line_d;
                    end
                end
            end

            StWrite: begin
                if (mem_resp) begin
                    cnt_d = cnt_q + CntW'(1);
                    if (last_beat) begin
                        state_d     = StDone;
                        mem_write_d = 1'b0;
                        pmem_resp_d = 1'b1;
                    end else begin
                        mem_wdata_d = line_q[cnt_d*BEAT_W +: BEAT_W];
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            line_q        <= '0;
            pmem_rdata_q  <= '0;
            pmem_resp_q   <= 1'b0;
            mem_address_q <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            line_q        <= line_d;
            pmem_rdata_q  <= pmem_rdata_d;
            pmem_resp_q   <= pmem_resp_d;
            mem_address_q <= mem_address_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    assign pmem_rdata  = pmem_rdata_q;
    assign pmem_resp   = pmem_resp_q;
    assign mem_address = mem_address_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_wdata   = mem_wdata_q;

endmodule

// File: doc/pmem_line_responder.md
Name: pmem_line_responder

Overview:
- Memory-side responder for the cache's 256-bit physical-memory port.
- Accepts one line read or line write from a cache (pmem_address / pmem_read / pmem_write / pmem_wdata) and answers with pmem_rdata / pmem_resp.
- Converts each line into a BEATS-long burst on a 64-bit main-memory bus, then returns a single-cycle completion pulse to the cache.

Parameters:
- LINE_W, 256, cacheline width in bits (matches cacheline_t).
- BEAT_W, 64, memory bus width per beat.
- BEATS, LINE_W/BEAT_W = 4, beats per line; BEATS must be a power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- pmem_address  in  32  line address from cache; bits [4:0] are ignored.
- pmem_read  in  1  line read request.
- pmem_write  in  1  line write request.
- pmem_wdata  in  LINE_W  writeback line.
- pmem_rdata  out  LINE_W  assembled read line.
- pmem_resp  out  1  one-cycle completion pulse.
- mem_address  out  32  line-aligned burst address.
- mem_read  out  1  burst read request.
- mem_write  out  1  burst write request.
- mem_wdata  out  BEAT_W  current write beat.
- mem_rdata  in  BEAT_W  current read beat.
- mem_resp  in  1  beat accepted (write) or valid (read).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, beat counter=0, pmem_rdata=0, pmem_resp=0, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0. The block leaves reset on the first clk edge with rst=1.
- All outputs are registered. mem_wdata is the beat-select of the latched write line.
- States:
  - IDLE:
    - pmem_write=1 → latch {pmem_address[31:5],5'b0} and pmem_wdata, then go to WRITE.
    - Else pmem_read=1 → latch the address, then go to READ.
    - Both asserted: write wins, and the read is serviced after write completion if still held.
    - mem_resp in IDLE is ignored.
  - READ:
    - mem_read=1 and mem_address=latched address.
    - Each cycle with mem_resp=1: store mem_rdata into line slot [cnt*BEAT_W +: BEAT_W] (beat 0 = bits [63:0]), then cnt++.
    - On the beat with cnt=BEATS-1: mem_read drops next cycle, cnt wraps to 0, go to DONE.
  - WRITE:
    - mem_write=1 and mem_wdata=latched line slot [cnt].
    - Each cycle with mem_resp=1: cnt++, and mem_wdata advances to the next beat in the following cycle.
    - Last beat → go to DONE, with the same wrap rule as READ.
  - DONE: pmem_resp=1 for exactly one cycle, then unconditionally back to IDLE.
    - pmem_rdata is valid in the DONE cycle. It holds until the next read's DONE; writes do not alter it.
- Timing:
  - Request seen at edge 0 → mem_read/mem_write high after edge 0 (cycle 1).
  - Back-to-back mem_resp in cycles k..k+3 → pmem_resp high in cycle k+4.
  - Minimum line latency is BEATS+2 cycles.
- Gaps in mem_resp (stalls between beats) are allowed; the counter holds and mem_wdata holds.
- Request deassertion mid-transaction is ignored; the burst completes and pmem_resp still pulses.
- IDLE cannot accept a new request in the DONE cycle. Back-to-back transactions therefore have ≥1 idle cycle.
- The latched address and data are immune to changes of pmem_address/pmem_wdata after acceptance.
- Reset mid-burst: immediate abort to IDLE, with no pmem_resp. Partial beats are discarded and pmem_rdata is cleared to 0.

Test Plan:
- Reset: hold rst=0 with random inputs → all outputs 0. Release → IDLE; mem_resp pulses are ignored with no pmem_resp.
- Read: pmem_read, addr 0x0000_1234; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on back-to-back mem_resp.
  - mem_address=0x0000_1220.
  - pmem_rdata={0x44..,0x33..,0x22..,0x11..}.
  - pmem_resp 1 cycle, exactly 5 cycles after mem_read rises.
- Write: pmem_write, addr 0x8000_00E0, wdata=beats {D3,D2,D1,D0}.
  - mem_wdata sequence D0,D1,D2,D3 in order.
  - mem_resp stalled 2 cycles after beat 1 → D2 held through the stall; single pmem_resp.
- Simultaneous pmem_read=pmem_write=1 on addr 0x40:
  - Write burst first, then pmem_resp.
  - Read issued after ≥1 idle cycle, with its own pmem_resp.
  - Total of 2 pulses.
- Mid-burst: deassert pmem_read after beat 1 → burst still completes with pmem_resp. Then start a write and assert rst=0 after beat 2 → outputs 0 immediately, no pmem_resp, and the next read starts cleanly with cnt=0.
- Data isolation: change pmem_wdata/pmem_address every cycle during a write → mem_address and mem_wdata show only the originally latched values.
